// File: rtl/block_retire_tracker.sv
// rtl/block_retire_tracker.sv - in-order block issue/retire tracker for one looper lane
//
// Accepts block offsets from one lane of the block looper, issues them to
// the compute pipeline in arrival order, and retires the oldest issued block
// once both its compute and its write-back have reported done.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   src_rdy/src_ack  upstream offset handshake, i_bofs carries the offset
//   dst_rdy/dst_ack  issue handshake to compute, o_bofs carries the offset
//   i_cmp_done       pulse: compute finished the oldest unfinished block
//   i_wb_done        pulse: write-back finished the oldest unfinished block
//   o_blkdone_dval   pulse: oldest block fully retired
//   o_n_pending      blocks accepted and not yet retired
//   o_err            sticky: a done pulse arrived with no block to credit

package TauCfg;
  localparam int WORK_BW           = 8;
  localparam int VDIM              = 2;
  localparam int MAX_PENDING_BLOCK = 4;
endpackage

module block_retire_tracker #(
  parameter int WBW       = TauCfg::WORK_BW,
  parameter int VDIM      = TauCfg::VDIM,
  parameter int N_PENDING = TauCfg::MAX_PENDING_BLOCK,
  localparam int CN       = $clog2(N_PENDING + 1),
  localparam int PW       = CN - 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     src_rdy,
  output logic                     src_ack,
  input  logic [VDIM-1:0][WBW-1:0] i_bofs,
  output logic                     dst_rdy,
  input  logic                     dst_ack,
  output logic [VDIM-1:0][WBW-1:0] o_bofs,
  input  logic                     i_cmp_done,
  input  logic                     i_wb_done,
  output logic                     o_blkdone_dval,
  output logic [CN-1:0]            o_n_pending,
  output logic                     o_err
);

  logic [VDIM-1:0][WBW-1:0] mem [N_PENDING];
  logic [PW-1:0]            wr_ptr, iss_ptr, ret_ptr;
  logic [CN-1:0]            n_pending, cmp_cnt, wb_cnt;
  logic                     dst_rdy_q, blkdone_q, err_q;
  logic [VDIM-1:0][WBW-1:0] bofs_q;

  logic                     acc, fire, cmp_ok, wb_ok, ret;
  logic                     all_issued, dst_rdy_nxt;
  logic [CN-1:0]            n_issued, unissued_left;
  logic [PW-1:0]            iss_ptr_nxt;
  logic [VDIM-1:0][WBW-1:0] bofs_nxt;

  assign acc  = src_rdy && (n_pending != CN'(N_PENDING)) && !i_rst;
  assign fire = dst_rdy_q && dst_ack;

  // Issued-and-unretired count from the pointer distance. Equal pointers
  // mean either none or all issued; dst_rdy_q is 1 exactly when an unissued
  // entry exists, so a full tracker with dst_rdy_q low has everything issued.
  assign all_issued = (iss_ptr == ret_ptr) && (n_pending == CN'(N_PENDING)) && !dst_rdy_q;
  assign n_issued   = all_issued ? CN'(N_PENDING) : {1'b0, PW'(iss_ptr - ret_ptr)};

  // A done pulse is only credited if an issued block is still waiting for it.
  assign cmp_ok = i_cmp_done && (cmp_cnt < n_issued);
  assign wb_ok  = i_wb_done && (wb_cnt < n_issued);

  // Retire looks at this cycle's pulses too, so a block retires the cycle
  // after its second done pulse rather than two cycles later.
  assign ret = (cmp_ok || (cmp_cnt != '0)) && (wb_ok || (wb_cnt != '0));

  // Unissued entries left after this cycle's issue, not counting this
  // cycle's accept; when zero, the only candidate to present next is i_bofs.
  assign unissued_left = n_pending - n_issued - CN'(fire);
  assign iss_ptr_nxt   = iss_ptr + PW'(fire);
  assign dst_rdy_nxt   = (unissued_left != '0) || acc;

  always_comb begin
    bofs_nxt = mem[iss_ptr_nxt];
    if (unissued_left == '0) bofs_nxt = i_bofs;
  end

  always_ff @(posedge i_clk) begin
    if (acc) mem[wr_ptr] <= i_bofs;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      iss_ptr   <= '0;
      ret_ptr   <= '0;
      n_pending <= '0;
      cmp_cnt   <= '0;
      wb_cnt    <= '0;
      dst_rdy_q <= 1'b0;
      blkdone_q <= 1'b0;
      err_q     <= 1'b0;
      bofs_q    <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(acc);
      iss_ptr   <= iss_ptr_nxt;
      ret_ptr   <= ret_ptr + PW'(ret);
      n_pending <= n_pending + CN'(acc) - CN'(ret);
      cmp_cnt   <= cmp_cnt + CN'(cmp_ok) - CN'(ret);
      wb_cnt    <= wb_cnt + CN'(wb_ok) - CN'(ret);
      dst_rdy_q <= dst_rdy_nxt;
      blkdone_q <= ret;
      err_q     <= err_q || (i_cmp_done && !cmp_ok) || (i_wb_done && !wb_ok);
      // While stalled the issue pointer is unchanged, so this reloads the
      // same offset and o_bofs stays stable until dst_ack.
      if (dst_rdy_nxt) bofs_q <= bofs_nxt;
    end
  end

  assign src_ack        = acc;
  assign dst_rdy        = dst_rdy_q;
  assign o_bofs         = bofs_q;
  assign o_blkdone_dval = blkdone_q;
  assign o_n_pending    = n_pending;
  assign o_err          = err_q;

endmodule

// File: tb/tb_block_retire_tracker.sv
// tb/tb_block_retire_tracker.sv - directed scoreboard bench for block_retire_tracker
module tb_block_retire_tracker;
  localparam int WBW  = 8;
  localparam int VDIM = 2;
  localparam int NP   = 4;
  localparam int CN   = $clog2(NP + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, src_rdy, src_ack, dst_rdy, dst_ack;
  logic                     cmp_done, wb_done, blkdone, err;
  logic [VDIM-1:0][WBW-1:0] i_bofs, o_bofs;
  logic [CN-1:0]            n_pending;

  block_retire_tracker #(.WBW(WBW), .VDIM(VDIM), .N_PENDING(NP)) dut (
    .i_clk(clk), .i_rst(rst),
    .src_rdy(src_rdy), .src_ack(src_ack), .i_bofs(i_bofs),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack), .o_bofs(o_bofs),
    .i_cmp_done(cmp_done), .i_wb_done(wb_done),
    .o_blkdone_dval(blkdone), .o_n_pending(n_pending), .o_err(err)
  );

  int n_pass = 0, n_total = 0;
  logic [15:0] exp_q[$];
  int n_acc = 0, n_iss = 0, n_ret = 0, n_cmp = 0, n_wb = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One clock: observe handshakes at the falling edge, return 1 after the rising edge.
  task automatic cycle();
    logic [15:0] e;
    @(negedge clk);
    if (!rst && src_rdy && src_ack) begin
      exp_q.push_back(i_bofs);
      n_acc++;
    end
    if (dst_rdy && dst_ack) begin
      n_iss++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_issue_bofs", o_bofs, e);
      end
    end
    if (!rst && cmp_done) n_cmp++;
    if (!rst && wb_done) n_wb++;
    if (blkdone) n_ret++;
    @(posedge clk);
    #1;
  endtask

  // Feed n_new offsets {k,0} and drain everything with random, ordered dones.
  task automatic run(input int n_new, input int budget);
    int acc_base, acc_tgt, cyc;
    acc_base = n_acc;
    acc_tgt  = n_acc + n_new;
    cyc      = 0;
    dst_ack  = 1'b1;
    while ((n_ret < acc_tgt || n_acc < acc_tgt) && cyc < budget) begin
      src_rdy  = (n_acc < acc_tgt);
      i_bofs   = {8'(n_acc - acc_base), 8'h00};
      cmp_done = (n_cmp < n_iss) && ($urandom_range(0, 1) == 1);
      wb_done  = (n_wb < n_iss) && ($urandom_range(0, 1) == 1);
      cycle();
      cyc++;
    end
    src_rdy = 0; dst_ack = 0; cmp_done = 0; wb_done = 0;
    check("run_retired", n_ret, acc_tgt);
    check("run_accepted", n_acc - acc_base, n_new);
    check("run_pending_zero", n_pending, 0);
    check("run_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_base, ret_base;
    rst = 1; src_rdy = 1; dst_ack = 0; cmp_done = 0; wb_done = 0; i_bofs = '0;
    cycle();
    check("rst_src_ack", src_ack, 0);
    cycle();
    check("rst_dst_rdy", dst_rdy, 0);
    check("rst_n_pending", n_pending, 0);
    check("rst_err", err, 0);
    check("rst_bofs", o_bofs, 0);
    check("rst_blkdone", blkdone, 0);
    rst = 0; src_rdy = 0;

    // Single block {3,5}
    src_rdy = 1; i_bofs = {8'd3, 8'd5};
    cycle();
    src_rdy = 0;
    check("single_acc", n_acc, 1);
    check("single_dst_rdy", dst_rdy, 1);
    check("single_bofs", o_bofs, 16'h0305);
    check("single_pending1", n_pending, 1);
    dst_ack = 1;
    cycle();
    dst_ack = 0; cmp_done = 1;
    cycle();
    cmp_done = 0;
    check("single_no_ret_on_cmp", blkdone, 0);
    wb_done = 1;
    cycle();
    wb_done = 0;
    check("single_blkdone", blkdone, 1);
    check("single_pending0", n_pending, 0);
    cycle();
    check("single_blkdone_pulse", blkdone, 0);
    check("single_ret_count", n_ret, 1);
    check("single_dst_idle", dst_rdy, 0);

    // Fill with dst_ack held low
    acc_base = n_acc;
    src_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      i_bofs = {8'(8'h10 + i), 8'h00};
      cycle();
    end
    check("fill_acks", n_acc - acc_base, 4);
    check("fill_pending", n_pending, 4);
    check("fill_dst_rdy", dst_rdy, 1);
    check("fill_bofs_held", o_bofs, 16'h1000);
    #1;
    check("fill_src_ack_low", src_ack, 0);
    dst_ack = 1;
    cycle();
    dst_ack = 0; cmp_done = 1; wb_done = 1; i_bofs = 16'h2000;
    cycle();
    cmp_done = 0; wb_done = 0;
    check("fill_ret_pulse", blkdone, 1);
    check("fill_pending3", n_pending, 3);
    check("fill_no_acc_on_ret", n_acc - acc_base, 4);
    #1;
    check("fill_src_ack_resume", src_ack, 1);
    cycle();
    src_rdy = 0;
    check("fill_acc_after", n_acc - acc_base, 5);
    check("fill_pending4", n_pending, 4);
    run(0, 300);

    // Wrap: ten blocks through a depth-4 tracker
    run(10, 2000);
    check("wrap_err", err, 0);

    // Simultaneous accept and retire
    src_rdy = 1; i_bofs = 16'h3300;
    cycle();
    src_rdy = 0; dst_ack = 1;
    cycle();
    dst_ack = 0;
    ret_base = n_ret;
    src_rdy = 1; i_bofs = 16'h3400; cmp_done = 1; wb_done = 1;
    cycle();
    src_rdy = 0; cmp_done = 0; wb_done = 0;
    check("simul_blkdone", blkdone, 1);
    check("simul_pending", n_pending, 1);
    cycle();
    check("simul_single_pulse", n_ret - ret_base, 1);
    run(0, 300);

    // Error: write-back done with nothing issued
    wb_done = 1;
    cycle();
    wb_done = 0;
    n_wb--;
    check("err_set", err, 1);
    cycle();
    check("err_sticky", err, 1);
    src_rdy = 1; i_bofs = 16'h4400;
    cycle();
    src_rdy = 0; dst_ack = 1;
    cycle();
    dst_ack = 0; cmp_done = 1;
    cycle();
    cmp_done = 0;
    check("err_wb_cnt_zero", blkdone, 0);
    cycle();
    check("err_wb_cnt_zero2", blkdone, 0);
    wb_done = 1;
    cycle();
    wb_done = 0;
    check("err_ret_after", blkdone, 1);
    check("err_still_set", err, 1);
    cycle();

    // Reset with three pending blocks
    src_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      i_bofs = {8'(8'h50 + i), 8'h01};
      cycle();
    end
    src_rdy = 0;
    check("rst3_pending", n_pending, 3);
    check("rst3_dst_rdy", dst_rdy, 1);
    ret_base = n_ret;
    rst = 1;
    cycle();
    rst = 0;
    exp_q.delete();
    check("rst3_dst_rdy0", dst_rdy, 0);
    check("rst3_pending0", n_pending, 0);
    check("rst3_err0", err, 0);
    check("rst3_bofs0", o_bofs, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("rst3_no_retire", n_ret - ret_base, 0);
    check("rst3_idle", dst_rdy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/block_retire_tracker.md
BLOCK_RETIRE_TRACKER -- requirements
Module: block_retire_tracker

Interface
REQ-001 SHALL have parameter WBW, default TauCfg::WORK_BW, width of one block-offset coordinate.
REQ-002 SHALL have parameter VDIM, default TauCfg::VDIM, number of offset dimensions.
REQ-003 SHALL have parameter N_PENDING, default TauCfg::MAX_PENDING_BLOCK, tracker depth (power of 2, >=2); CN = $clog2(N_PENDING+1).
REQ-004 i_clk  input  1  clock; single clock domain.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 src_rdy  input  1  upstream block offset valid (one tau lane of the parallel block looper).
REQ-007 src_ack  output  1  upstream offset accepted this cycle.
REQ-008 i_bofs  input  WBW x [VDIM]  block offset.
REQ-009 dst_rdy  output  1  block issued to the compute pipeline.
REQ-010 dst_ack  input  1  compute pipeline accepts the issued block.
REQ-011 o_bofs  output  WBW x [VDIM]  offset of the issued block.
REQ-012 i_cmp_done  input  1  one-cycle pulse; compute finished the oldest unfinished issued block.
REQ-013 i_wb_done  input  1  one-cycle pulse; write-back finished the oldest unfinished issued block.
REQ-014 o_blkdone_dval  output  1  one-cycle pulse; oldest block fully retired (feeds the looper's per-lane done semaphore).
REQ-015 o_n_pending  output  CN  blocks accepted and not yet retired.
REQ-016 o_err  output  1  sticky protocol-error flag.

Function
REQ-017 Handshake rule: a transfer occurs when rdy&&ack; dst_rdy and o_bofs SHALL stay stable from assertion until dst_ack.
REQ-018 Storage: circular buffer of N_PENDING offsets with write, issue and retire pointers (each CN-1 bits, wrap N_PENDING-1 -> 0).
REQ-019 src_ack SHALL equal src_rdy && (o_n_pending != N_PENDING); accepted offset written at write pointer, write pointer increments.
REQ-020 dst_rdy SHALL be registered; asserted the cycle after an unissued entry exists, o_bofs loaded from issue pointer in the same cycle; no combinational path src_rdy -> dst_rdy.
REQ-021 On dst_ack the issue pointer increments; if another unissued entry exists dst_rdy SHALL remain 1 and o_bofs update next cycle (back-to-back issue, one block per cycle).
REQ-022 Per-source done counters cmp_cnt, wb_cnt (CN bits) SHALL increment on their pulse and count blocks finished but not retired.
REQ-023 Retire condition: cmp_cnt>0 && wb_cnt>0; then o_blkdone_dval=1 (registered, asserted the cycle after the condition), both counters decrement, retire pointer increments, o_n_pending decrements; at most one retire per cycle.
REQ-024 Simultaneous increment and retire-decrement on one counter SHALL leave it unchanged; simultaneous src_ack and retire SHALL leave o_n_pending unchanged.
REQ-025 Full: o_n_pending==N_PENDING deasserts src_ack; a retire in the same cycle does not re-enable src_ack until the next cycle.
REQ-026 Empty: o_n_pending==0 keeps dst_rdy=0 and o_blkdone_dval=0.
REQ-027 A done pulse exceeding issued-and-unretired blocks (cmp_cnt or wb_cnt would exceed issued count) SHALL be dropped and set o_err=1 until reset.
REQ-028 Done pulses SHALL be in issue order; the block does not tag or reorder.

Reset
REQ-029 On i_rst=1 at a rising edge: all pointers, counters, o_n_pending, dst_rdy, o_blkdone_dval, o_err SHALL become 0; o_bofs SHALL become all zeros.
REQ-030 Reset mid-operation SHALL discard every pending block with no o_blkdone_dval pulse; src_ack SHALL be 0 while i_rst=1.

Verification
REQ-031 Single block: i_bofs={3,5}, src handshake, dst_ack next cycle, cmp then wb pulse -> dst_rdy one cycle after accept with o_bofs={3,5}; one o_blkdone_dval one cycle after wb pulse; o_n_pending 1->0.
REQ-032 Fill: N_PENDING=4, dst_ack=0, src_rdy held -> exactly 4 acks, src_ack=0 thereafter, o_n_pending=4; one retire -> src_ack resumes the cycle after.
REQ-033 Wrap: 10 blocks offsets {k,0}, dst_ack=1 always, dones random but ordered -> 10 retire pulses, issue order k=0..9, pointers wrap without loss.
REQ-034 Simultaneous: cmp and wb pulse together with a new src accept -> exactly one retire pulse, o_n_pending unchanged.
REQ-035 Error: i_wb_done pulse with zero issued blocks -> o_err=1 and stays 1, wb_cnt stays 0.
REQ-036 Reset with 3 pending blocks and dst_rdy=1 -> next cycle dst_rdy=0, o_n_pending=0, no o_blkdone_dval pulse.
